// File: rtl/alu_ctr.sv
// -----------------------------------------------------------------------------
// alu_ctr
//
// ALU control decoder for the MIPS datapath. Combines the 2-bit operation
// class from the main control unit with the R-type funct field and produces
// the 3-bit ALU operation select. The result is registered, so it appears one
// cycle after the inputs and lines up with the EX stage register boundary.
// Unsupported R-type funct codes decode to ADD and raise the illegal flag.
//
// Ports:
//   clk      in   1  system clock, rising-edge active
//   reset    in   1  synchronous, active-high reset (ALUoper=ADD, illegal=0)
//   ALUop    in   2  operation class: 00 ADD, 01 SUB, 11 OR, 10 R-type
//   Func     in   6  instruction[5:0] funct field (used only when ALUop=10)
//   ALUoper  out  3  registered ALU operation select
//   illegal  out  1  registered flag: R-type with unsupported funct
// -----------------------------------------------------------------------------
module alu_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ALUop,
    input  logic [5:0] Func,
    output logic [2:0] ALUoper,
    output logic       illegal
);

    // ALU operation encodings (101 is never produced)
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // R-type funct decode: {illegal, ALUoper}. Unsigned variants (addu, subu,
    // sltu) share the ALU operation of their signed counterparts.
    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        logic [3:0] r;
        case (f)
            6'b100000: r = {1'b0, OP_ADD};
            6'b100001: r = {1'b0, OP_ADD};
            6'b100010: r = {1'b0, OP_SUB};
            6'b100011: r = {1'b0, OP_SUB};
            6'b100100: r = {1'b0, OP_AND};
            6'b100101: r = {1'b0, OP_OR};
            6'b100110: r = {1'b0, OP_XOR};
            6'b100111: r = {1'b0, OP_NOR};
            6'b101010: r = {1'b0, OP_SLT};
            6'b101011: r = {1'b0, OP_SLT};
            default:   r = {1'b1, OP_ADD};
        endcase
        return r;
    endfunction

    // Full decode: only the R-type class looks at Func.
    function automatic logic [3:0] decode_aluop(input logic [1:0] op,
                                                input logic [5:0] f);
        logic [3:0] r;
        case (op)
            2'b00:   r = {1'b0, OP_ADD};
            2'b01:   r = {1'b0, OP_SUB};
            2'b11:   r = {1'b0, OP_OR};
            default: r = decode_funct(f);
        endcase
        return r;
    endfunction

    // ---- stage p0: combinational decode of the current inputs ----
    logic [2:0] aluoper_p0;
    logic       illegal_p0;

    always_comb begin
        {illegal_p0, aluoper_p0} = decode_aluop(ALUop, Func);
    end

    // ---- stage p1: registered outputs, reset forces ADD / not illegal ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUoper <= OP_ADD;
            illegal <= 1'b0;
        end else begin
            ALUoper <= aluoper_p0;
            illegal <= illegal_p0;
        end
    end

endmodule

// File: tb/tb_alu_ctr.sv
// -----------------------------------------------------------------------------
// tb_alu_ctr
//
// Directed testbench for alu_ctr. Each step drives the inputs, pushes the
// expected registered result to a scoreboard queue, then after the next
// rising edge pops it and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_alu_ctr;

    logic       clk;
    logic       reset;
    logic [1:0] ALUop;
    logic [5:0] Func;
    logic [2:0] ALUoper;
    logic       illegal;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [2:0] oper;
        logic       ill;
        string      tag;
    } exp_t;

    exp_t sb[$];

    alu_ctr dut (
        .clk    (clk),
        .reset  (reset),
        .ALUop  (ALUop),
        .Func   (Func),
        .ALUoper(ALUoper),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for R-type funct codes, built from the funct bit fields.
    function automatic logic [3:0] ref_rtype(input logic [5:0] f);
        logic [2:0] o;
        logic       ok;
        ok = (f[5:4] == 2'b10) && ((f[3:0] <= 4'd7) || (f[3:0] == 4'd10) || (f[3:0] == 4'd11));
        if (!ok)
            o = 3'b010;
        else if (f[3])
            o = 3'b111;
        else if (f[2:1] == 2'b00)
            o = 3'b010;
        else if (f[2:1] == 2'b01)
            o = 3'b110;
        else if (f[2:1] == 2'b10)
            o = f[0] ? 3'b001 : 3'b000;
        else
            o = f[0] ? 3'b100 : 3'b011;
        return {~ok, o};
    endfunction

    task automatic check_val(input string tag, input logic [2:0] eo, input logic ei);
        n_vec++;
        assert (ALUoper === eo) else begin
            n_bad++;
            $error("FAIL %s ALUoper: got %b want %b", tag, ALUoper, eo);
        end
        assert (illegal === ei) else begin
            n_bad++;
            $error("FAIL %s illegal: got %b want %b", tag, illegal, ei);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard empty");
        end else begin
            e = sb.pop_front();
            check_val(e.tag, e.oper, e.ill);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f,
                        input logic [2:0] eo, input logic ei, input string tag);
        exp_t e;
        reset = r;
        ALUop = op;
        Func  = f;
        e.oper = eo;
        e.ill  = ei;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic [3:0] m;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        ALUop = 2'b10;
        Func  = 6'b100111;
        @(negedge clk);

        // Reset held two edges with NOR inputs present
        step(1'b1, 2'b10, 6'b100111, 3'b010, 1'b0, "reset1");
        step(1'b1, 2'b10, 6'b100111, 3'b010, 1'b0, "reset2");
        step(1'b0, 2'b10, 6'b100111, 3'b100, 1'b0, "post_reset_nor");

        // Non-R-type classes ignore Func
        step(1'b0, 2'b11, 6'b100000, 3'b001, 1'b0, "ori");
        step(1'b0, 2'b00, 6'b100000, 3'b010, 1'b0, "lw_sw");
        step(1'b0, 2'b01, 6'b100000, 3'b110, 1'b0, "beq");

        // R-type funct sweep
        step(1'b0, 2'b10, 6'b100000, 3'b010, 1'b0, "add");
        step(1'b0, 2'b10, 6'b100010, 3'b110, 1'b0, "sub");
        step(1'b0, 2'b10, 6'b100100, 3'b000, 1'b0, "and");
        step(1'b0, 2'b10, 6'b100101, 3'b001, 1'b0, "or");
        step(1'b0, 2'b10, 6'b100110, 3'b011, 1'b0, "xor");
        step(1'b0, 2'b10, 6'b100111, 3'b100, 1'b0, "nor");
        step(1'b0, 2'b10, 6'b101010, 3'b111, 1'b0, "slt");
        step(1'b0, 2'b10, 6'b101011, 3'b111, 1'b0, "sltu");
        step(1'b0, 2'b10, 6'b100001, 3'b010, 1'b0, "addu");
        step(1'b0, 2'b10, 6'b100011, 3'b110, 1'b0, "subu");

        // Unsupported funct codes, then a non-R-type class with the same Func
        step(1'b0, 2'b10, 6'b000000, 3'b010, 1'b1, "ill_000000");
        step(1'b0, 2'b00, 6'b000000, 3'b010, 1'b0, "lw_000000");
        step(1'b0, 2'b10, 6'b111111, 3'b010, 1'b1, "ill_111111");
        step(1'b0, 2'b00, 6'b111111, 3'b010, 1'b0, "lw_111111");
        step(1'b0, 2'b11, 6'b111111, 3'b001, 1'b0, "ori_111111");
        step(1'b0, 2'b01, 6'b101000, 3'b110, 1'b0, "beq_101000");

        // Every funct code under R-type against the bit-field reference
        for (int i = 0; i < 64; i++) begin
            m = ref_rtype(6'(i));
            step(1'b0, 2'b10, 6'(i), m[2:0], m[3], $sformatf("sweep_%02h", i));
        end

        // Latency: set SUB, then change inputs 1 ns after the edge
        step(1'b0, 2'b01, 6'b000000, 3'b110, 1'b0, "lat_setup");
        ALUop = 2'b10;
        Func  = 6'b100100;
        #3;
        check_val("lat_hold", 3'b110, 1'b0);
        @(posedge clk);
        #1;
        check_val("lat_update", 3'b000, 1'b0);
        Func = 6'b000001;
        #3;
        check_val("lat_hold2", 3'b000, 1'b0);
        @(posedge clk);
        #1;
        check_val("lat_update2", 3'b010, 1'b1);

        // Reset mid-stream with beq running
        step(1'b0, 2'b01, 6'b000000, 3'b110, 1'b0, "mid_run");
        step(1'b1, 2'b01, 6'b000000, 3'b010, 1'b0, "mid_reset");
        step(1'b0, 2'b01, 6'b000000, 3'b110, 1'b0, "mid_release");
        step(1'b1, 2'b10, 6'b111111, 3'b010, 1'b0, "reset_masks_illegal");
        step(1'b0, 2'b10, 6'b111111, 3'b010, 1'b1, "illegal_after_reset");

        if (sb.size() != 0) begin
            n_bad++;
            $error("FAIL scoreboard leftover: got %0d want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_ctr.md
Name: alu_ctr

Overview:
- ALU control decoder for the single-cycle/pipelined MIPS datapath.
- Maps the 2-bit ALUop from the main control unit and the 6-bit R-type funct field to a 3-bit ALU operation code.
- Output is registered: one-cycle latency, so it lines up with the EX stage register boundary.
- Also flags unsupported funct codes.

Parameters:
- None. All widths are fixed: ALUop 2, Func 6, ALUoper 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- ALUop  input  2  operation class from the main control unit
- Func  input  6  instruction[5:0] funct field
- ALUoper  output  3  registered ALU operation select
- illegal  output  1  registered flag: R-type with unsupported funct

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - At a rising clk edge with reset=1: ALUoper <= 3'b010 (ADD), illegal <= 0. Reset takes priority over any input.
  - Otherwise both outputs load the combinational decode of the current ALUop/Func.
  - Latency is exactly one cycle. There is no handshake, stall or enable: a new decode is produced every cycle.
- ALUoper encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 NOR
  - 110 SUB
  - 111 SLT
  - 101 is never produced.
- ALUop decode:
  - 00 (lw/sw/addi): ADD. Func is ignored.
  - 01 (beq/bne): SUB. Func is ignored.
  - 11 (ori): OR. Func is ignored, even when it holds a valid R-type funct.
  - 10 (R-type): decode Func as follows.
    - 100000 add and 100001 addu -> ADD
    - 100010 sub and 100011 subu -> SUB
    - 100100 and -> AND
    - 100101 or -> OR
    - 100110 xor -> XOR
    - 100111 nor -> NOR
    - 101010 slt and 101011 sltu -> SLT
    - Any other Func -> ADD with illegal=1.
- illegal is 1 only when ALUop=10 and Func is unsupported; it is 0 for every other input.
- Inputs X/Z are not handled; the implementation must use a full case with an explicit default so no latches are inferred.
- Boundary conditions:
  - Input changes between edges have no visible effect until the next edge.
  - Reset asserted mid-stream overrides the pending decode for that edge.
  - The first non-reset edge after reset deassertion outputs the decode of the inputs present at that edge.

Test Plan:
- Reset: reset=1 for 2 cycles with ALUop=10, Func=100111 -> ALUoper=010, illegal=0. Deassert reset -> next edge ALUoper=100.
- ALUop=11, Func=100000 -> after one edge ALUoper=001 (OR, Func ignored), illegal=0. ALUop=00 -> 010. ALUop=01 -> 110.
- ALUop=10, sweep Func:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 100110 -> 011
  - 100111 -> 100
  - 101010 -> 111
  - 101011 -> 111
  - 100001 -> 010
  - 100011 -> 110
  - illegal=0 throughout.
- ALUop=10, Func=000000 or 111111 -> ALUoper=010, illegal=1. Then ALUop=00 with the same Func -> illegal=0.
- Latency check: change inputs 1 ns after an edge -> outputs hold the old value until the next edge, then update exactly once.
- Reset mid-stream: ALUop=01 running, assert reset for one edge -> ALUoper=010. Release reset -> next edge ALUoper=110.
